// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding, operand mux
// selects and the default operand width.
// Latency: n/a (types only). Backpressure: n/a.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Operand register next-value source: fresh input or subtractor result.
    typedef enum logic {
        SEL_IN  = 1'b0,
        SEL_SUB = 1'b1
    } opsel_e;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the GCD engine: sequences accept, subtract loop and result hold.
// Latency: strobes are combinational from registered state and comparator flags.
// Backpressure: holds DONE while out_ready is low; in_ready only in IDLE.
//
// Ports: clk/rst (sync, active-high); comparator flags a_eq_0, b_eq_0, a_eq_b,
// a_gt_b; handshake in_valid/out_ready; strobes a_ld, b_ld, op_sel, cnt_clr,
// cnt_inc, done_load, res_sel_b; status in_ready, out_valid.
module gcd_ctrl
    import gcd_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   a_eq_0,
    input  logic   b_eq_0,
    input  logic   a_eq_b,
    input  logic   a_gt_b,
    input  logic   in_valid,
    input  logic   out_ready,
    output logic   a_ld,
    output logic   b_ld,
    output opsel_e op_sel,
    output logic   cnt_clr,
    output logic   cnt_inc,
    output logic   done_load,
    output logic   res_sel_b,
    output logic   in_ready,
    output logic   out_valid
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Decoded from registered state only: no in_valid/out_ready -> output path.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        op_sel    = SEL_SUB;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        done_load = 1'b0;
        res_sel_b = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_ld    = 1'b1;
                    b_ld    = 1'b1;
                    op_sel  = SEL_IN;
                    cnt_clr = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (a_eq_0) begin
                    // Covers gcd(0,0)=0 and gcd(0,x)=x.
                    done_load = 1'b1;
                    res_sel_b = 1'b1;
                    state_d   = S_DONE;
                end else if (b_eq_0 || a_eq_b) begin
                    done_load = 1'b1;
                    state_d   = S_DONE;
                end else if (a_gt_b) begin
                    a_ld    = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    b_ld    = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;  // unused encoding recovers to IDLE
        endcase
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative Euclid-by-subtraction GCD unit, one subtraction per clock.
// Latency: result valid N+2 cycles after the accept cycle (N = subtractions).
// Backpressure: result and count held in DONE until out_ready; one job in flight.
//
// Ports: clk, rst (sync, active-high); a_in/b_in operands with in_valid/in_ready;
// gcd_out with out_valid/out_ready; iter_count saturating subtraction count.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] iter_count
);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] minuend, subtrahend, diff;
    logic             a_eq_0, b_eq_0, a_eq_b, a_gt_b;
    logic             a_ld, b_ld, cnt_clr, cnt_inc, done_load, res_sel_b;
    opsel_e           op_sel;

    assign a_eq_0 = (a_q == '0);
    assign b_eq_0 = (b_q == '0);
    assign a_eq_b = (a_q == b_q);
    assign a_gt_b = (a_q > b_q);

    // Single subtractor: the larger operand is always the minuend, so no underflow.
    assign minuend    = a_gt_b ? a_q : b_q;
    assign subtrahend = a_gt_b ? b_q : a_q;
    assign diff       = minuend - subtrahend;

    gcd_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .a_eq_0    (a_eq_0),
        .b_eq_0    (b_eq_0),
        .a_eq_b    (a_eq_b),
        .a_gt_b    (a_gt_b),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .a_ld      (a_ld),
        .b_ld      (b_ld),
        .op_sel    (op_sel),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .done_load (done_load),
        .res_sel_b (res_sel_b),
        .in_ready  (in_ready),
        .out_valid (out_valid)
    );

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (a_ld) a_d = (op_sel == SEL_IN) ? a_in : diff;
        if (b_ld) b_d = (op_sel == SEL_IN) ? b_in : diff;

        res_d = res_q;
        if (done_load) res_d = res_sel_b ? b_q : a_q;

        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign gcd_out    = res_q;
    assign iter_count = cnt_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine with a result scoreboard.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected (gcd, N, latency) tuples are queued when a job is launched.
module tb_gcd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_in, b_in;
    logic        in_valid, in_ready;
    logic [15:0] gcd_out;
    logic        out_valid, out_ready;
    logic [15:0] iter_count;

    typedef struct {
        int g;
        int n;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_in       (a_in),
        .b_in       (b_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gcd_out    (gcd_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Launch a job: push expectation, wait for in_ready, take the accept edge.
    // in_valid is left high when keep is set.
    task automatic start_job(input int a, input int b, input int g, input int n, input bit keep);
        exp_t e;
        int   w;
        e.g = g;
        e.n = n;
        e.lat = n + 2;
        sb.push_back(e);
        a_in     = 16'(a);
        b_in     = 16'(b);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        tick();  // accept edge: now in cycle 1
        if (!keep) in_valid = 1'b0;
    endtask

    // Wait for out_valid counting cycles from the accept cycle, then score.
    task automatic wait_result(input string tag);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (!out_valid && cyc < 70000) begin
            tick();
            cyc++;
        end
        chk({tag, "_seen"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_gcd"}, 32'(gcd_out), 32'(e.g));
            chk({tag, "_iter"}, 32'(iter_count), 32'(e.n));
            chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        end
    endtask

    initial begin
        rst       = 1'b1;
        a_in      = '0;
        b_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_gcd", 32'(gcd_out), 32'd0);
        chk("rst_iter", 32'(iter_count), 32'd0);
        rst = 1'b0;
        tick();

        // Basic job, out_valid exactly one cycle with out_ready high.
        start_job(12, 8, 4, 2, 1'b0);
        wait_result("basic");
        tick();
        chk("basic_valid_drop", 32'(out_valid), 32'd0);
        chk("basic_idle_ready", 32'(in_ready), 32'd1);
        chk("basic_hold_gcd", 32'(gcd_out), 32'd4);

        // Zero and equal operands.
        start_job(0, 0, 0, 0, 1'b0);
        wait_result("z00");
        tick();
        start_job(0, 25, 25, 0, 1'b0);
        wait_result("z0x");
        tick();
        start_job(30, 0, 30, 0, 1'b0);
        wait_result("zx0");
        tick();
        start_job(7, 7, 7, 0, 1'b0);
        wait_result("eq");
        tick();

        // Reset mid-job aborts: no result for (48,18).
        a_in     = 16'd48;
        b_in     = 16'd18;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_gcd", 32'(gcd_out), 32'd0);
        chk("abort_iter", 32'(iter_count), 32'd0);
        tick();
        chk("abort_idle_out_valid", 32'(out_valid), 32'd0);
        chk("abort_idle_in_ready", 32'(in_ready), 32'd1);

        // Backpressure: result held, second request ignored.
        out_ready = 1'b0;
        start_job(48, 18, 6, 4, 1'b0);
        wait_result("bp");
        a_in     = 16'd5;
        b_in     = 16'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i % 3 == 0) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_gcd", 32'(gcd_out), 32'd6);
                chk("bp_hold_iter", 32'(iter_count), 32'd4);
                chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_gcd", 32'(gcd_out), 32'd6);
        tick();
        chk("bp_no_stray_job", 32'(in_ready), 32'd1);

        // Back-to-back with in_valid held high.
        start_job(100, 75, 25, 3, 1'b1);
        a_in = 16'd21;
        b_in = 16'd14;
        chk("b2b_busy_ready", 32'(in_ready), 32'd0);
        wait_result("b2b_first");
        tick();
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);
        start_job(21, 14, 7, 2, 1'b0);
        wait_result("b2b_second");
        tick();

        // Long coprime case.
        start_job(65535, 1, 1, 65534, 1'b0);
        wait_result("coprime");
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
